// File: rtl/byte_mix_sequencer_pkg.sv
// Shared types and constants for the byte mix sequencer.
package byte_mix_sequencer_pkg;

  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned ROUNDS_DEF   = 4;
  localparam int unsigned ROUND_W_DEF  = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/byte_mix_sequencer.sv
// Serial-load front end that iterates an external byte mixer ROUNDS times
// and holds the final byte on result with a one-cycle done pulse.
module byte_mix_sequencer
  import byte_mix_sequencer_pkg::*;
#(
  parameter int unsigned ROUNDS  = ROUNDS_DEF,
  parameter int unsigned ROUND_W = ROUND_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ser_in,
  input  logic              load,
  input  logic              start,
  output logic [BYTE_W-1:0] mix_in,
  input  logic [BYTE_W-1:0] mix_res,
  output logic [BYTE_W-1:0] result,
  output logic              busy,
  output logic              done
);

  localparam logic [ROUND_W-1:0] LAST_CNT = ROUND_W'(ROUNDS - 1);

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   work_q, work_d;
  logic [BYTE_W-1:0]   result_q, result_d;
  logic [ROUND_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      work_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        // start wins over load so a run never begins on a half-shifted byte
        if (start) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else if (load) begin
          work_d = {work_q[BYTE_W-2:0], ser_in};
        end
      end
      S_RUN: begin
        work_d = mix_res;
        cnt_d  = cnt_q + ROUND_W'(1);
        if (cnt_q == LAST_CNT) begin
          result_d = mix_res;
          state_d  = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign mix_in = work_q;
  assign result = result_q;
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_byte_mix_sequencer.sv
// Randomized check of two sequencer builds (ROUNDS=4 and ROUNDS=1) against a
// transaction-level model using an increment stub as the mixer.
module tb_byte_mix_sequencer;

  logic       clk;
  logic       rst;
  logic       ser_in;
  logic       load;
  logic       start;
  logic [7:0] mix_in_a  [2];
  logic [7:0] mix_res_a [2];
  logic [7:0] result_a  [2];
  logic       busy_a    [2];
  logic       done_a    [2];

  int n_checks;
  int n_errors;

  int         m_rounds [2];
  int         m_el     [2];
  logic [7:0] m_work   [2];
  logic [7:0] m_sw     [2];
  logic [7:0] m_result [2];

  assign mix_res_a[0] = mix_in_a[0] + 8'd1;
  assign mix_res_a[1] = mix_in_a[1] + 8'd1;

  byte_mix_sequencer #(.ROUNDS(4), .ROUND_W(3)) u_dut4 (
    .clk(clk), .rst(rst), .ser_in(ser_in), .load(load), .start(start),
    .mix_in(mix_in_a[0]), .mix_res(mix_res_a[0]), .result(result_a[0]),
    .busy(busy_a[0]), .done(done_a[0])
  );

  byte_mix_sequencer #(.ROUNDS(1), .ROUND_W(3)) u_dut1 (
    .clk(clk), .rst(rst), .ser_in(ser_in), .load(load), .start(start),
    .mix_in(mix_in_a[1]), .mix_res(mix_res_a[1]), .result(result_a[1]),
    .busy(busy_a[1]), .done(done_a[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Elapsed-cycle view of a run: work = start byte + rounds elapsed.
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_el[i]     = -1;
      m_work[i]   = 8'h00;
      m_sw[i]     = 8'h00;
      m_result[i] = 8'h00;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_el[i] = -1; m_work[i] = 8'h00; m_result[i] = 8'h00;
      end else if (m_el[i] < 0) begin
        if (start) begin
          m_sw[i] = m_work[i];
          m_el[i] = 0;
        end else if (load) begin
          m_work[i] = {m_work[i][6:0], ser_in};
        end
      end else if (m_el[i] == m_rounds[i]) begin
        m_el[i] = -1;
      end else begin
        m_el[i]   = m_el[i] + 1;
        m_work[i] = m_sw[i] + 8'(m_el[i]);
        if (m_el[i] == m_rounds[i]) m_result[i] = m_work[i];
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("mix_in[%0d]", i), 32'(mix_in_a[i]), 32'(m_work[i]));
      chk($sformatf("result[%0d]", i), 32'(result_a[i]), 32'(m_result[i]));
      chk($sformatf("busy[%0d]", i),   32'(busy_a[i]),   32'(m_el[i] >= 0));
      chk($sformatf("done[%0d]", i),   32'(done_a[i]),   32'(m_el[i] == m_rounds[i]));
    end
  endtask

  // Called at a negedge (or before the next posedge); returns at the next negedge.
  task automatic step(input logic s, input logic ld, input logic st);
    ser_in = s; load = ld; start = st;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    for (int k = 0; k < 3; k++) step(1'($urandom), 1'($urandom), 1'($urandom));
    rst = 1'b0;
  endtask

  task automatic load_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) step(b[k], 1'b1, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_rounds[0] = 4;
    m_rounds[1] = 1;
    rst = 1'b0; ser_in = 1'b0; load = 1'b0; start = 1'b0;
    model_reset();

    @(negedge clk);
    async_reset();
    chk("reset_result", 32'(result_a[0]), 32'h00);

    // 0x3C, four rounds of +1 -> 0x40; single round -> 0x3D
    load_byte(8'h3C);
    step(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b0);
    chk("dir_3c_r4", 32'(result_a[0]), 32'h40);
    chk("dir_3c_r1", 32'(result_a[1]), 32'h3D);

    // start beats load; 0xA5 + 4 -> 0xA9
    load_byte(8'hA5);
    step(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 1'b0);
    chk("dir_a5_r4", 32'(result_a[0]), 32'hA9);

    // reset two cycles into a run, then 0xFF wraps to 0x03
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    async_reset();
    chk("dir_abort_r4", 32'(result_a[0]), 32'h00);
    load_byte(8'hFF);
    step(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b0);
    chk("dir_ff_r4", 32'(result_a[0]), 32'h03);
    chk("dir_ff_r1", 32'(result_a[1]), 32'h00);

    // back-to-back starts on the one-round build: 0x10 -> 0x11 -> 0x12
    load_byte(8'h10);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("dir_10_r1", 32'(result_a[1]), 32'h11);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("dir_10_again_r1", 32'(result_a[1]), 32'h12);

    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 99) == 0) async_reset();
      else step(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
